// File: rtl/bitcount_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bitcount_exec_unit
//  Description : Multi-cycle CLZ / CTZ / CPOP execute unit. The latched
//                operand is scanned one chunk per cycle, MSB-first. CTZ is
//                handled as CLZ of the bit-reversed operand. Latency is fixed:
//                done pulses in the cycle after edge E+N+1 for a start
//                accepted at edge E.
//                Build option: define BITCOUNT_WIDE_CHUNK_EN for 4-bit chunks
//                (N=8); otherwise 1-bit chunks (N=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module bitcount_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  alu_control,
    input  logic [31:0] src_a,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        stall
);

`ifdef BITCOUNT_WIDE_CHUNK_EN
    localparam int c_W = 4;
`else
    localparam int c_W = 1;
`endif
    localparam logic [5:0] c_N        = 6'(32 / c_W);
    localparam logic [3:0] c_ALU_CLZ  = 4'b0111;
    localparam logic [3:0] c_ALU_CTZ  = 4'b0110;
    localparam logic [3:0] c_ALU_CPOP = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_op;
    logic             r_pop;
    logic             r_found;
    logic [5:0]       r_count;
    logic [5:0]       r_idx;
    logic [5:0]       r_result;
    logic [31:0]      w_src_rev;
    logic             w_legal;
    logic             w_accept;
    logic [c_W-1:0]   w_chunk;
    logic [5:0]       w_lz;
    logic [5:0]       w_pop;
    logic             w_seen;

    // Bit-reversed operand so that CTZ reuses the MSB-first leading-zero scan
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev
            assign w_src_rev[gi] = src_a[31-gi];
        end
    endgenerate

    assign w_legal  = (alu_control == c_ALU_CLZ) || (alu_control == c_ALU_CTZ) ||
                      (alu_control == c_ALU_CPOP);
    assign w_accept = (r_state == S_IDLE) && start && w_legal && !flush;
    assign w_chunk  = r_op[31 -: c_W];

    // Leading-zero count and population count of the chunk under examination
    always_comb begin
        w_lz   = 6'(c_W);
        w_pop  = 6'd0;
        w_seen = 1'b0;
        for (int i = c_W - 1; i >= 0; i--) begin
            if (w_chunk[i]) begin
                if (!w_seen) begin
                    w_lz = 6'(c_W - 1 - i);
                end
                w_seen = 1'b1;
                w_pop  = w_pop + 6'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush aborts from any state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RUN;
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_idx == c_N) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, per-chunk accumulation and final result capture.
    // The cycle with r_idx == N only publishes the count into the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 32'd0;
            r_pop    <= 1'b0;
            r_found  <= 1'b0;
            r_count  <= 6'd0;
            r_idx    <= 6'd0;
            r_result <= 6'd0;
        end else if (w_accept) begin
            r_op    <= (alu_control == c_ALU_CTZ) ? w_src_rev : src_a;
            r_pop   <= (alu_control == c_ALU_CPOP);
            r_found <= 1'b0;
            r_count <= 6'd0;
            r_idx   <= 6'd0;
        end else if ((r_state == S_RUN) && !flush) begin
            if (r_idx < c_N) begin
                r_op  <= r_op << c_W;
                r_idx <= r_idx + 6'd1;
                if (r_pop) begin
                    r_count <= r_count + w_pop;
                end else if (!r_found) begin
                    r_count <= r_count + w_lz;
                    if (w_seen) begin
                        r_found <= 1'b1;
                    end
                end
            end else begin
                r_result <= r_count;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = {26'd0, r_result};
    // Gated by rst_n so the hold request drops immediately during reset
    assign stall  = rst_n && (w_accept || (r_state == S_RUN));

endmodule
`default_nettype wire

// File: tb/tb_bitcount_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitcount_exec_unit
//  Description : Directed, table-driven self-checking bench for
//                bitcount_exec_unit, plus sequences for flush, ignored
//                starts and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitcount_exec_unit;

`ifdef BITCOUNT_WIDE_CHUNK_EN
    localparam int N = 8;
`else
    localparam int N = 32;
`endif
    localparam logic [3:0] CLZ  = 4'b0111;
    localparam logic [3:0] CTZ  = 4'b0110;
    localparam logic [3:0] CPOP = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] src_a = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done, stall;
    logic [31:0] result;

    int ntests = 0;
    int nfail  = 0;

    bitcount_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .src_a(src_a), .flush(flush), .busy(busy), .done(done),
        .result(result), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one op, measure edges from acceptance to the done cycle
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          output int lat, output logic [31:0] res,
                          output logic stall_ok, output logic after_ok);
        @(negedge clk);
        start = 1'b1; alu_control = op; src_a = a;
        #1 stall_ok = (stall === 1'b1);
        @(negedge clk);
        start = 1'b0; alu_control = 4'd0; src_a = 32'd0;
        lat = -1; res = 32'hDEAD_BEEF; after_ok = 1'b0;
        for (int j = 0; j < N + 20; j++) begin
            if (done === 1'b1) begin
                lat = j;
                res = result;
                stall_ok = stall_ok && (stall === 1'b0);
                break;
            end
            stall_ok = stall_ok && (stall === 1'b1);
            @(negedge clk);
        end
        if (lat >= 0) begin
            @(negedge clk);
            after_ok = (done === 1'b0) && (busy === 1'b0) && (result === res);
        end
    endtask

    int          lat;
    logic [31:0] res;
    logic        sok, aok;
    int          ndone;
    logic [31:0] prev;

    initial begin
        vecs[0]  = '{CLZ,  32'h0001_0000, 32'd15};
        vecs[1]  = '{CTZ,  32'h0001_0000, 32'd16};
        vecs[2]  = '{CTZ,  32'h0000_0000, 32'd32};
        vecs[3]  = '{CLZ,  32'h0000_0000, 32'd32};
        vecs[4]  = '{CPOP, 32'h0000_0000, 32'd0};
        vecs[5]  = '{CPOP, 32'hF0F0_000F, 32'd12};
        vecs[6]  = '{CPOP, 32'hFFFF_FFFF, 32'd32};
        vecs[7]  = '{CLZ,  32'hFFFF_FFFF, 32'd0};
        vecs[8]  = '{CTZ,  32'hFFFF_FFFF, 32'd0};
        vecs[9]  = '{CLZ,  32'h0000_0001, 32'd31};
        vecs[10] = '{CTZ,  32'h8000_0000, 32'd31};
        vecs[11] = '{CLZ,  32'h0000_0F00, 32'd20};
        vecs[12] = '{CTZ,  32'h0000_0F00, 32'd8};
        vecs[13] = '{CPOP, 32'h1234_5678, 32'd13};
        vecs[14] = '{CLZ,  32'h0800_0000, 32'd4};
        vecs[15] = '{CTZ,  32'h0000_0010, 32'd4};

        // Reset state
        #2;
        chk("reset_busy",   {31'd0, busy},  32'd0);
        chk("reset_done",   {31'd0, done},  32'd0);
        chk("reset_stall",  {31'd0, stall}, 32'd0);
        chk("reset_result", result,         32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int k = 0; k < 16; k++) begin
            run_op(vecs[k].op, vecs[k].a, lat, res, sok, aok);
            chk($sformatf("v%0d_latency", k), lat, N + 1);
            chk($sformatf("v%0d_result", k), res, vecs[k].exp);
            chk($sformatf("v%0d_stall", k), {31'd0, sok}, 32'd1);
            chk($sformatf("v%0d_after", k), {31'd0, aok}, 32'd1);
        end

        // Flush three cycles after start: abort, no done, result kept
        prev = result;
        @(negedge clk);
        start = 1'b1; alu_control = CLZ; src_a = 32'h8000_0000;
        @(negedge clk);
        start = 1'b0; alu_control = 4'd0;
        @(negedge clk); @(negedge clk);
        flush = 1'b1;
        ndone = 0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",   {31'd0, busy},  32'd0);
        chk("flush_stall",  {31'd0, stall}, 32'd0);
        chk("flush_result", result,         prev);
        run_op(CPOP, 32'hF0F0_000F, lat, res, sok, aok);
        chk("flush_next_latency", lat, N + 1);
        chk("flush_next_result",  res, 32'd12);

        // Illegal code ignored, then a second start during RUN ignored
        @(negedge clk);
        start = 1'b1; alu_control = 4'b0000; src_a = 32'h0000_0001;
        #1 chk("illegal_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("illegal_busy",   {31'd0, busy}, 32'd0);
        chk("illegal_result", result,        32'd12);
        start = 1'b1; alu_control = CTZ; src_a = 32'h0001_0000;
        @(negedge clk);
        start = 1'b0; alu_control = 4'd0; src_a = 32'd0;
        @(negedge clk); @(negedge clk);
        start = 1'b1; alu_control = CPOP; src_a = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; alu_control = 4'd0; src_a = 32'd0;
        ndone = 0;
        for (int j = 0; j < 3 * N + 10; j++) begin
            if (done === 1'b1) begin
                ndone++;
                chk("busy_start_result", result, 32'd16);
            end
            @(negedge clk);
        end
        chk("busy_start_done_count", ndone, 1);
        chk("busy_start_idle_busy",  {31'd0, busy}, 32'd0);

        // Reset mid-RUN: outputs clear asynchronously, no done afterwards
        @(negedge clk);
        start = 1'b1; alu_control = CLZ; src_a = 32'h0001_0000;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 4; j++) @(negedge clk);
        #2 rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        chk("rst_result", result,         32'd0);
        start = 1'b0; alu_control = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 2 * N + 5; j++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("rst_no_done_after", ndone, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
